// File: rtl/alu_cmd_master.sv
// alu_cmd_master: host-side initiator for the UART ALU command protocol.
// Sends operand A, operand B and the opcode byte through uart_tx, then
// waits for a one-byte result from uart_rx, with a bounded wait.
// Optional macro ALU_CMD_RETRY_EN: on a result timeout, re-send the whole
// command up to MAX_RETRY times before reporting timeout_err.
module alu_cmd_master #(
    parameter int NB_DATA     = 8,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NB_DATA-1:0] op_a,
    input  logic [NB_DATA-1:0] op_b,
    input  logic [NB_DATA-3:0] op_code,
    output logic               busy,
    output logic               done,
    output logic [NB_DATA-1:0] result,
    output logic               timeout_err,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    input  logic               tx_done_tick,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_DATA-3:0] op_q;
    logic [CNT_W-1:0]   cnt;
    logic               early;   // result already captured while OP byte was in flight

`ifdef ALU_CMD_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry_cnt;
`endif

    // Command sequencer: all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt         <= '0;
            early       <= 1'b0;
`ifdef ALU_CMD_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            tx_start    <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coincident with the done pulse is dropped.
                    if (start && !done) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        op_q     <= op_code;
                        early    <= 1'b0;
                        busy     <= 1'b1;
                        tx_start <= 1'b1;
                        tx_data  <= op_a;
                        state    <= SEND_A;
`ifdef ALU_CMD_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                SEND_A:  state <= WAIT_A;
                WAIT_A: begin
                    if (tx_done_tick) begin
                        tx_start <= 1'b1;
                        tx_data  <= b_q;
                        state    <= SEND_B;
                    end
                end
                SEND_B:  state <= WAIT_B;
                WAIT_B: begin
                    if (tx_done_tick) begin
                        tx_start <= 1'b1;
                        tx_data  <= {2'b00, op_q};
                        state    <= SEND_OP;
                    end
                end
                SEND_OP: state <= WAIT_OP;
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        result <= rx_data;
                        early  <= 1'b1;
                    end
                    if (tx_done_tick) begin
                        if (early || rx_done_tick) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    if (rx_done_tick) begin
                        result <= rx_data;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == CNT_LAST) begin
`ifdef ALU_CMD_RETRY_EN
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            early     <= 1'b0;
                            tx_start  <= 1'b1;
                            tx_data   <= a_q;
                            state     <= SEND_A;
                        end else begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
`else
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master: randomized commands against a
// transaction-level model (expected byte queue, expected result, event counts).
module tb_alu_cmd_master;

    localparam int NB = 8;
    localparam int TO = 100;
    localparam int MR = 2;
`ifdef ALU_CMD_RETRY_EN
    localparam int NSEQ = MR + 1;
`else
    localparam int NSEQ = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NB-1:0] op_a = '0, op_b = '0;
    logic [NB-3:0] op_code = '0;
    logic          busy, done, timeout_err, tx_start;
    logic [NB-1:0] result, tx_data;
    logic          tx_done_tick = 1'b0;
    logic          rx_done_tick = 1'b0;
    logic [NB-1:0] rx_data = '0;

    int checks = 0, errors = 0;
    int done_seen = 0, to_seen = 0, exp_done = 0, exp_to = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] model_result = '0;
    logic [NB-1:0] cur_a, cur_b, cur_c;

    alu_cmd_master #(.NB_DATA(NB), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .op_code(op_code), .busy(busy), .done(done), .result(result),
        .timeout_err(timeout_err), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Compare process: every transmitted byte must be the next expected one,
    // completion events must leave busy low, and an idle block shows the model result.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_start) begin
                if (exp_q.size() == 0) chk("tx_start_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (done) begin
                done_seen++;
                chk("done_busy", 32'(busy), 0);
                chk("done_result", 32'(result), 32'(model_result));
            end
            if (timeout_err) begin
                to_seen++;
                chk("to_busy", 32'(busy), 0);
            end
            if (!busy) chk("idle_result", 32'(result), 32'(model_result));
        end
    end

    task automatic push_cmd();
        exp_q.push_back(cur_a);
        exp_q.push_back(cur_b);
        exp_q.push_back(cur_c);
    endtask

    task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-3:0] c);
        cur_a = a; cur_b = b; cur_c = {2'b00, c};
        op_a = a; op_b = b; op_code = c; start = 1'b1;
        push_cmd();
        tick();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 1);
        chk("first_tx_start", 32'(tx_start), 1);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_start && n < 60) begin tick(); n++; end
        if (!tx_start) chk("wait_tx_start_timeout", 0, 1);
    endtask

    // Play uart_tx for one frame; optionally inject an rx byte or a stray start.
    task automatic serve(input int dly, input int rx_at, input logic [NB-1:0] rx_v,
                         input bit rx_valid, input int restart_at);
        logic [NB-1:0] t0;
        wait_tx();
        t0 = tx_data;
        for (int i = 1; i <= dly; i++) begin
            rx_done_tick = (i == rx_at);
            rx_data = rx_v;
            if (i == rx_at && rx_valid) model_result = rx_v;
            if (i == restart_at) begin start = 1'b1; op_a = 8'hFF; op_b = 8'hEE; end
            tick();
            rx_done_tick = 1'b0;
            start = 1'b0;
            chk("tx_hold", 32'(tx_data), 32'(t0));
        end
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic serve3();
        for (int f = 0; f < 3; f++) serve($urandom_range(1, 6), 0, 8'h00, 0, 0);
    endtask

    // Called on the first cycle after the OP frame completes.
    task automatic respond(input int at, input logic [NB-1:0] v);
        for (int k = 1; k < at; k++) tick();
        rx_done_tick = 1'b1; rx_data = v; model_result = v;
        tick();
        rx_done_tick = 1'b0;
        exp_done++;
        chk("resp_done", 32'(done), 1);
        chk("resp_busy", 32'(busy), 0);
        chk("resp_to", 32'(timeout_err), 0);
        chk("resp_result", 32'(result), 32'(v));
    endtask

    task automatic no_response(input bit final_seq);
        bit early_evt = 0;
        for (int k = 1; k < TO + 1; k++) begin
            if (timeout_err || done || tx_start) early_evt = 1;
            if (k == TO && !final_seq) push_cmd();
            tick();
        end
        chk("no_early_event", 32'(early_evt), 0);
        if (final_seq) begin
            exp_to++;
            chk("timeout_pulse", 32'(timeout_err), 1);
            chk("timeout_busy", 32'(busy), 0);
            tick();
            chk("timeout_one_cycle", 32'(timeout_err), 0);
        end else begin
            chk("retry_tx_start", 32'(tx_start), 1);
            chk("retry_no_to", 32'(timeout_err), 0);
            chk("retry_busy", 32'(busy), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] a, b, v;
        logic [NB-3:0] c;
        int dly, mode;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_to", 32'(timeout_err), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        reset = 1'b0;
        tick();

        // Basic command: 05, 03, 20 -> 08; a start in the done cycle is ignored.
        issue(8'h05, 8'h03, 6'h20);
        chk("basic_first_byte", 32'(tx_data), 32'h05);
        serve3();
        respond(3, 8'h08);
        start = 1'b1; op_a = 8'h77;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", 32'(tx_start), 0);
        chk("start_in_done_busy", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        chk("basic_result_kept", 32'(result), 32'h08);
        tick();

        // No response: timeout (after all retries when enabled), result unchanged.
        issue(8'h12, 8'h34, 6'h01);
        for (int s = 0; s < NSEQ; s++) begin
            serve3();
            no_response(s == NSEQ - 1);
        end
        chk("timeout_result_kept", 32'(result), 32'h08);

`ifdef ALU_CMD_RETRY_EN
        // Response during the second retry completes the command.
        issue(8'h21, 8'h22, 6'h23);
        for (int s = 0; s < 2; s++) begin serve3(); no_response(0); end
        serve3();
        respond(5, 8'h3C);
        tick();
`endif

        // Robustness: rx byte during WAIT_A and start during WAIT_B are ignored.
        issue(8'h21, 8'h42, 6'h03);
        serve(4, 2, 8'hAA, 0, 0);
        chk("stray_rx_ignored", 32'(result), 32'(model_result));
        serve(4, 0, 8'h00, 0, 2);
        serve(3, 0, 8'h00, 0, 0);
        respond(7, 8'h63);
        tick();

        // Early result in WAIT_OP: done right after the OP frame completes.
        issue(8'h0A, 8'h07, 6'h02);
        serve(2, 0, 8'h00, 0, 0);
        serve(2, 0, 8'h00, 0, 0);
        serve(4, 2, 8'h11, 1, 0);
        exp_done++;
        chk("early_done", 32'(done), 1);
        chk("early_busy", 32'(busy), 0);
        chk("early_result", 32'(result), 32'h11);
        tick();
        chk("early_done_one_cycle", 32'(done), 0);

        // Tie: rx byte on the last counted cycle wins over the timeout.
        issue(8'h33, 8'h44, 6'h05);
        serve3();
        respond(TO, 8'h5A);
        tick();

        // Reset in WAIT_B, then a fresh command starts with operand A.
        issue(8'h05, 8'h03, 6'h20);
        serve(3, 0, 8'h00, 0, 0);
        wait_tx();
        tick();
        reset = 1'b1; model_result = '0;
        exp_q.delete();
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tx_start", 32'(tx_start), 0);
        reset = 1'b0;
        tick();
        issue(8'h05, 8'h03, 6'h20);
        chk("post_rst_first_byte", 32'(tx_data), 32'h05);
        serve3();
        respond(2, 8'h08);
        tick();

        // Randomized commands; responder returns a+b, early or in WAIT_RES.
        for (int n = 0; n < 8; n++) begin
            a = NB'($urandom); b = NB'($urandom); c = (NB-2)'($urandom);
            v = a + b;
            mode = $urandom_range(0, 1);
            issue(a, b, c);
            serve($urandom_range(1, 6), 0, 8'h00, 0, 0);
            serve($urandom_range(1, 6), 0, 8'h00, 0, 0);
            if (mode == 0) begin
                dly = $urandom_range(2, 8);
                serve(dly, $urandom_range(2, dly), v, 1, 0);
                exp_done++;
                chk("rand_early_done", 32'(done), 1);
                chk("rand_early_result", 32'(result), 32'(v));
            end else begin
                serve($urandom_range(1, 6), 0, 8'h00, 0, 0);
                respond($urandom_range(1, TO), v);
            end
            tick();
        end

        repeat (5) tick();
        chk("done_count", 32'(done_seen), 32'(exp_done));
        chk("timeout_count", 32'(to_seen), 32'(exp_to));
        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Host-side initiator for the UART ALU command protocol. It is the opposite end of the on-board interface FSM.
- Takes operand A, operand B and an opcode from a local requester, sends them as three UART bytes through a uart_tx instance, then waits for the one-byte result from a uart_rx instance.
- Used in board-to-board links and in loopback benches against the existing UART/FIFO/interface/ALU top.
- Shares the baud generator and uart_rx/uart_tx handshake conventions.

Parameters:
- NB_DATA, 8, UART byte and operand width.
- TIMEOUT_CYC, 2_000_000, clk cycles allowed in WAIT_RES before a timeout is declared. Must be ≥ 2.
- MAX_RETRY, 2, number of re-sends after a timeout. Used only when ALU_CMD_RETRY_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled in IDLE only
- op_a  in  NB_DATA  operand A
- op_b  in  NB_DATA  operand B
- op_code  in  NB_DATA-2  ALU opcode
- busy  out  1  high from start acceptance until done or timeout_err
- done  out  1  one-cycle pulse when the result is valid
- result  out  NB_DATA  received result; held until the next accepted start
- timeout_err  out  1  one-cycle pulse when a command is abandoned
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  NB_DATA  byte to uart_tx; stable from the tx_start cycle until tx_done_tick
- tx_done_tick  in  1  uart_tx frame-complete pulse
- rx_done_tick  in  1  uart_rx byte-valid pulse
- rx_data  in  NB_DATA  uart_rx byte

Behaviour:
- Reset values: busy=0, done=0, result=0, timeout_err=0, tx_start=0, tx_data=0, state=IDLE, timeout counter=0, retry count=0.
- Reset mid-operation returns to IDLE on the next edge and drops tx_start immediately. An in-flight uart_tx frame is not aborted by this block.
- States: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES.
- IDLE: on start=1, latch op_a, op_b and op_code; set busy=1; go to SEND_A.
- SEND_x (one cycle): tx_start=1; tx_data = latched byte; go to WAIT_x.
- Opcode byte is {2'b00, op_code}.
- WAIT_A on tx_done_tick → SEND_B. WAIT_B on tx_done_tick → SEND_OP. WAIT_OP on tx_done_tick → WAIT_RES, clearing the timeout counter.
- Byte order on the line: A, B, OP. First tx_start occurs 1 cycle after the start edge.
- Early result: an rx_done_tick in WAIT_OP is captured into result and flagged. On the following tx_done_tick the block goes directly to completion (done pulse) and skips WAIT_RES.
- WAIT_RES: the counter increments every cycle.
  - rx_done_tick → result<=rx_data; done=1 on the next cycle; busy=0 in that same cycle; go to IDLE.
  - Counter reaches TIMEOUT_CYC-1 with no rx_done_tick → timeout_err=1 for 1 cycle; busy=0; result unchanged; go to IDLE.
  - If rx_done_tick and the timeout fire in the same cycle, rx_done_tick wins.
- rx_done_tick in IDLE, SEND_x, WAIT_A or WAIT_B is discarded. result is not modified.
- start while busy=1 is ignored; there is no queueing. start in the same cycle that done is asserted is ignored. start is accepted from the cycle after done.
- tx_done_tick outside the WAIT_x states is ignored.
- Counter width: $clog2(TIMEOUT_CYC). There is no wrap; the counter saturates at the timeout compare.

Optional Feature:
- Macro ALU_CMD_RETRY_EN.
- Defined:
  - A WAIT_RES timeout with retry count < MAX_RETRY increments the retry count and returns to SEND_A, re-sending all three bytes. busy stays 1 and no timeout_err is issued.
  - timeout_err fires only after MAX_RETRY retries are exhausted.
  - The retry count clears on accepted start.
- Undefined: the first timeout aborts immediately. The retry counter logic is absent.

Test Plan:
- Basic command (TIMEOUT_CYC=100): op_a=0x05, op_b=0x03, op_code=6'h20, start pulse.
  - tx_start pulses carry tx_data 0x05, 0x03, 0x20 in order, each after the previous tx_done_tick.
  - Responder model returns 0x08 → result=0x08, one-cycle done, busy falls in the same cycle.
- Timeout, macro undefined: no rx byte after the OP frame → timeout_err pulses exactly 100 cycles after WAIT_RES entry; result keeps its prior value; busy=0.
- Retry, macro defined, MAX_RETRY=2, no response: 3 full A/B/OP sequences observed, then one timeout_err. Response 0x3C during the 2nd retry → done, result=0x3C, no timeout_err.
- Robustness: start re-pulsed during WAIT_B and rx byte 0xAA injected during WAIT_A → both ignored; the sequence completes normally with the later correct result.
- Early result and tie: result 0x11 arrives in WAIT_OP → done 1 cycle after the OP tx_done_tick. rx_done_tick coincident with the final timeout cycle → done, no timeout_err.
- Reset mid-op: assert reset in WAIT_B → next cycle busy=0 and tx_start=0; a new start then sends 0x05 first.
